pc_seq_unit: RTL and testbench
==============================

PC_SEQ_UNIT -- requirements
Module: pc_seq_unit

Interface
REQ-001 Parameter WIDTH, 32, PC/address width; legal values 32 or 64.
REQ-002 Parameter RESET_VECTOR, 32'h00400020 (zero-extended to WIDTH), PC value loaded on reset.
REQ-003 Parameter EXC_VECTOR, 32'h80000180 (zero-extended), PC value loaded on exception or address error.
REQ-004 clk  in  1  single clock; all state updates on rising edge.
REQ-005 reset  in  1  asynchronous, active-high reset.
REQ-006 stall  in  1  hold PC (pipeline freeze).
REQ-007 halt_req  in  1  enter HALTED state.
REQ-008 branch_taken  in  1  take PC-relative branch.
REQ-009 branch_off  in  16  signed word offset.
REQ-010 jump  in  1  take region jump.
REQ-011 jump_target  in  26  word index of jump target.
REQ-012 jr  in  1  take register jump.
REQ-013 jr_addr  in  WIDTH  register jump byte address.
REQ-014 exc  in  1  exception request.
REQ-015 eret  in  1  return from exception.
REQ-016 pc  out  WIDTH  current PC (registered).
REQ-017 pc_plus4  out  WIDTH  pc + 4, combinational.
REQ-018 epc  out  WIDTH  saved exception PC (registered).
REQ-019 addr_err  out  1  sticky misaligned-jr flag.
REQ-020 halted  out  1  high while in HALTED.

Function
REQ-021 States: RUN, HALTED, EXC_HOLD; encoding is implementation choice.
REQ-022 All arithmetic modulo 2^WIDTH; pc_plus4 wraps from all-ones-minus-3 to 0 without flag.
REQ-023 Branch target = pc_plus4 + (sign_extend(branch_off) << 2).
REQ-024 Jump target = {pc_plus4[WIDTH-1:28], jump_target, 2'b00}.
REQ-025 In RUN, next-PC priority: exc > eret > jr > jump > branch_taken > sequential (pc_plus4).
REQ-026 exc in RUN: pc <= EXC_VECTOR, epc <= pc, state -> EXC_HOLD; exc overrides stall and halt_req.
REQ-027 eret in RUN (no exc): pc <= epc, epc unchanged.
REQ-028 jr with jr_addr[1:0] != 0: treated as exception -- pc <= EXC_VECTOR, epc <= jr_addr, addr_err <= 1, state -> EXC_HOLD.
REQ-029 stall high in RUN with no exc: pc, epc, state hold; all other controls ignored.
REQ-030 halt_req in RUN with no exc and no stall: pc holds, state -> HALTED.
REQ-031 HALTED: pc holds, halted = 1; only exc leaves (same action as REQ-026); stall, halt_req, branch, jump, jr, eret ignored.
REQ-032 EXC_HOLD: lasts exactly one cycle, pc holds at EXC_VECTOR, all inputs ignored including exc; next state RUN.
REQ-033 addr_err clears only on reset.
REQ-034 Latency: redirect request sampled on edge N is visible on pc after edge N; pc_plus4 follows pc combinationally.

Reset
REQ-035 reset high asynchronously forces pc = RESET_VECTOR, epc = 0, addr_err = 0, state = RUN, halted = 0, independent of clk.
REQ-036 Reset asserted mid-operation (any state, stalled or not) overrides every input; first update after deassertion follows REQ-025 from RESET_VECTOR.

Verification
REQ-037 Reset then 3 idle cycles -> pc = 0x00400020, 0x00400024, 0x00400028, 0x0040002C.
REQ-038 pc = 0x00400040, branch_taken with branch_off = 0xFFFE -> pc = 0x0040003C; jump with jump_target = 0x0100010 -> pc = 0x00400040.
REQ-039 pc = 0x00400050, exc and jr same cycle -> pc = 0x80000180, epc = 0x00400050; next cycle pc holds; eret -> pc = 0x00400050.
REQ-040 jr_addr = 0x00400062 -> pc = 0x80000180, epc = 0x00400062, addr_err = 1 until reset.
REQ-041 halt_req at pc = 0x00400030 -> halted = 1, pc frozen 10 cycles despite jump/stall; exc -> pc = 0x80000180, halted = 0.
REQ-042 WIDTH = 64, pc = 0xFFFFFFFFFFFFFFFC, idle cycle -> pc = 0; async reset pulse between edges -> pc = RESET_VECTOR immediately.

Source files
------------

// File: rtl/pc_seq_unit_if.sv
// pc_seq_unit_if: control inputs and PC outputs of the program-counter sequencer.
interface pc_seq_unit_if #(parameter int WIDTH = 32);
    logic             stall;
    logic             halt_req;
    logic             branch_taken;
    logic [15:0]      branch_off;
    logic             jump;
    logic [25:0]      jump_target;
    logic             jr;
    logic [WIDTH-1:0] jr_addr;
    logic             exc;
    logic             eret;
    logic [WIDTH-1:0] pc;
    logic [WIDTH-1:0] pc_plus4;
    logic [WIDTH-1:0] epc;
    logic             addr_err;
    logic             halted;
    modport master (
        output stall, halt_req, branch_taken, branch_off, jump, jump_target, jr, jr_addr, exc, eret,
        input  pc, pc_plus4, epc, addr_err, halted
    );
    modport slave (
        input  stall, halt_req, branch_taken, branch_off, jump, jump_target, jr, jr_addr, exc, eret,
        output pc, pc_plus4, epc, addr_err, halted
    );
endinterface

// File: rtl/pc_seq_unit.sv
// pc_seq_unit: program counter sequencer with branch/jump/jr redirects,
// exception entry/return, halt and a one-cycle exception hold state.
module pc_seq_unit #(
    parameter int          WIDTH        = 32,
    parameter logic [31:0] RESET_VECTOR = 32'h00400020,
    parameter logic [31:0] EXC_VECTOR   = 32'h80000180
) (
    input logic         clk,
    input logic         reset,
    pc_seq_unit_if.slave bus
);
    typedef enum logic [1:0] {RUN, HALTED, EXC_HOLD} state_t;
    state_t           state, state_nx;
    logic [WIDTH-1:0] pc_nx, epc_nx, br_off;
    logic             err_nx;
    assign bus.pc_plus4 = bus.pc + WIDTH'(4);
    assign bus.halted   = state == HALTED;
    assign br_off       = {{(WIDTH-18){bus.branch_off[15]}}, bus.branch_off, 2'b00};
    always_comb begin
        pc_nx    = bus.pc;
        epc_nx   = bus.epc;
        err_nx   = bus.addr_err;
        state_nx = state;
        if (state == EXC_HOLD)
            state_nx = RUN;
        else if (bus.exc) begin
            pc_nx    = WIDTH'(EXC_VECTOR);
            epc_nx   = bus.pc;
            state_nx = EXC_HOLD;
        end else if (state == RUN && !bus.stall) begin
            if (bus.halt_req)
                state_nx = HALTED;
            else if (bus.eret)
                pc_nx = bus.epc;
            else if (bus.jr && bus.jr_addr[1:0] != 2'b00) begin
                // misaligned register jump is handled as an exception
                pc_nx    = WIDTH'(EXC_VECTOR);
                epc_nx   = bus.jr_addr;
                err_nx   = 1'b1;
                state_nx = EXC_HOLD;
            end else if (bus.jr)
                pc_nx = bus.jr_addr;
            else if (bus.jump)
                pc_nx = {bus.pc_plus4[WIDTH-1:28], bus.jump_target, 2'b00};
            else
                pc_nx = bus.branch_taken ? bus.pc_plus4 + br_off : bus.pc_plus4;
        end
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bus.pc       <= WIDTH'(RESET_VECTOR);
            bus.epc      <= '0;
            bus.addr_err <= 1'b0;
            state        <= RUN;
        end else begin
            bus.pc       <= pc_nx;
            bus.epc      <= epc_nx;
            bus.addr_err <= err_nx;
            state        <= state_nx;
        end
    end
endmodule

// File: tb/tb_pc_seq_unit.sv
// tb_pc_seq_unit: 32- and 64-bit sequencers driven in lockstep by directed and
// random stimulus, each checked against its own rule-level reference model.
module tb_pc_seq_unit;
    logic        clk = 1'b0;
    logic        reset;
    logic        stall, halt_req, branch_taken, jump, jr, exc, eret;
    logic [15:0] branch_off;
    logic [25:0] jump_target;
    logic [63:0] jr_addr;
    int          total = 0;
    int          bad = 0;

    localparam logic [63:0] RV = 64'h00400020;
    localparam logic [63:0] EV = 64'h80000180;
    localparam int M_RUN = 0, M_HALT = 1, M_HOLD = 2;

    logic [63:0] mpc[2], mepc[2], mask[2];
    bit          merr[2];
    int          mode[2];

    always #5 clk = ~clk;

    pc_seq_unit_if #(.WIDTH(32)) b32();
    pc_seq_unit_if #(.WIDTH(64)) b64();
    pc_seq_unit #(.WIDTH(32)) dut32 (.clk(clk), .reset(reset), .bus(b32.slave));
    pc_seq_unit #(.WIDTH(64)) dut64 (.clk(clk), .reset(reset), .bus(b64.slave));

    assign b32.stall = stall;           assign b64.stall = stall;
    assign b32.halt_req = halt_req;     assign b64.halt_req = halt_req;
    assign b32.branch_taken = branch_taken; assign b64.branch_taken = branch_taken;
    assign b32.branch_off = branch_off; assign b64.branch_off = branch_off;
    assign b32.jump = jump;             assign b64.jump = jump;
    assign b32.jump_target = jump_target; assign b64.jump_target = jump_target;
    assign b32.jr = jr;                 assign b64.jr = jr;
    assign b32.jr_addr = jr_addr[31:0]; assign b64.jr_addr = jr_addr;
    assign b32.exc = exc;               assign b64.exc = exc;
    assign b32.eret = eret;             assign b64.eret = eret;

    task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            mpc[k] = RV; mepc[k] = '0; merr[k] = 0; mode[k] = M_RUN;
        end
    endtask

    task automatic take_exc(int k, logic [63:0] saved);
        mpc[k] = EV; mepc[k] = saved & mask[k]; mode[k] = M_HOLD;
    endtask

    // one clock of architectural behaviour, computed from the current inputs
    task automatic model_step();
        for (int k = 0; k < 2; k++) begin
            logic [63:0] p4 = (mpc[k] + 64'd4) & mask[k];
            if (mode[k] == M_HOLD) mode[k] = M_RUN;
            else if (exc) take_exc(k, mpc[k]);
            else if (mode[k] == M_RUN && !stall) begin
                if (halt_req) mode[k] = M_HALT;
                else if (eret) mpc[k] = mepc[k];
                else if (jr && jr_addr[1:0] != 2'b00) begin
                    take_exc(k, jr_addr); merr[k] = 1;
                end else if (jr) mpc[k] = jr_addr & mask[k];
                else if (jump) mpc[k] = (p4 & ~64'h0FFFFFFF) | (64'(jump_target) * 4);
                else if (branch_taken) mpc[k] = (p4 + {{48{branch_off[15]}}, branch_off} * 4) & mask[k];
                else mpc[k] = p4;
            end
        end
    endtask

    task automatic compare_all();
        check("pc32", 64'(b32.pc), mpc[0]);
        check("pc4_32", 64'(b32.pc_plus4), (mpc[0] + 4) & mask[0]);
        check("epc32", 64'(b32.epc), mepc[0]);
        check("err32", 64'(b32.addr_err), 64'(merr[0]));
        check("halt32", 64'(b32.halted), 64'(mode[0] == M_HALT));
        check("pc64", b64.pc, mpc[1]);
        check("pc4_64", b64.pc_plus4, mpc[1] + 4);
        check("epc64", b64.epc, mepc[1]);
        check("err64", 64'(b64.addr_err), 64'(merr[1]));
        check("halt64", 64'(b64.halted), 64'(mode[1] == M_HALT));
    endtask

    task automatic idle();
        stall = 0; halt_req = 0; branch_taken = 0; jump = 0; jr = 0; exc = 0; eret = 0;
        branch_off = '0; jump_target = '0; jr_addr = '0;
    endtask

    task automatic cycle();
        model_step();
        @(posedge clk);
        #1;
        compare_all();
    endtask

    task automatic do_jr(logic [63:0] a);
        idle(); jr = 1; jr_addr = a; cycle(); idle();
    endtask

    task automatic pulse_reset();
        reset = 1;
        #1;
        model_reset();
        compare_all();
        check("async_rv", 64'(b32.pc), RV);
        reset = 0;
    endtask

    initial begin
        mask[0] = 64'hFFFF_FFFF;
        mask[1] = '1;
        reset = 1;
        idle();
        #3;
        model_reset();
        compare_all();
        @(negedge clk);
        reset = 0;
        for (int i = 0; i < 3; i++) cycle();
        check("seq3", 64'(b32.pc), 64'h0040002C);
        // branch back one word, then region jump
        do_jr(64'h00400040);
        branch_taken = 1; branch_off = 16'hFFFE; cycle(); idle();
        check("branch", 64'(b32.pc), 64'h0040003C);
        jump = 1; jump_target = 26'h0100010; cycle(); idle();
        check("jump", 64'(b32.pc), 64'h00400040);
        // exception beats jr, hold cycle, then return
        do_jr(64'h00400050);
        exc = 1; jr = 1; jr_addr = 64'h00400100; cycle(); idle();
        check("exc_pc", 64'(b32.pc), EV);
        check("exc_epc", 64'(b32.epc), 64'h00400050);
        exc = 1; eret = 1; cycle(); idle();
        check("hold_pc", 64'(b32.pc), EV);
        eret = 1; cycle(); idle();
        check("eret", 64'(b32.pc), 64'h00400050);
        do_jr(64'h00400062);
        check("misal_epc", 64'(b32.epc), 64'h00400062);
        for (int i = 0; i < 3; i++) cycle();
        check("err_sticky", 64'(b32.addr_err), 64'd1);
        // halt freezes the PC until an exception
        do_jr(64'h00400030);
        halt_req = 1; cycle(); idle();
        for (int i = 0; i < 10; i++) begin
            jump = 1; jump_target = 26'($urandom); stall = 1'($urandom);
            eret = 1'($urandom); jr = 1'($urandom); jr_addr = 64'h00400080;
            cycle(); idle();
        end
        check("halt_pc", 64'(b32.pc), 64'h00400030);
        exc = 1; cycle(); idle();
        check("halt_exc", 64'(b32.pc), EV);
        check("halt_clr", 64'(b32.halted), 64'd0);
        cycle();
        // wrap to zero on both widths
        do_jr(64'hFFFF_FFFF_FFFF_FFFC);
        cycle();
        check("wrap64", b64.pc, 64'd0);
        pulse_reset();
        for (int i = 0; i < 600; i++) begin
            idle();
            exc          = ($urandom_range(19) == 0);
            stall        = ($urandom_range(5) == 0);
            halt_req     = ($urandom_range(24) == 0);
            eret         = ($urandom_range(9) == 0);
            jr           = ($urandom_range(7) == 0);
            jr_addr      = {$urandom, $urandom};
            if ($urandom_range(3) != 0) jr_addr[1:0] = 2'b00;
            jump         = ($urandom_range(7) == 0);
            jump_target  = 26'($urandom);
            branch_taken = ($urandom_range(3) == 0);
            branch_off   = 16'($urandom);
            cycle();
            if ($urandom_range(99) == 0) pulse_reset();
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
